// File: rtl/arbitro_memoria_dados.sv
// Round-robin arbiter between two word-request ports sharing one single-port data memory.
// Each granted access spends one cycle in ACCESS and one in RESP, so the peak rate is one access every three cycles.
module arbitro_memoria_dados #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_a,
    input  logic              we_a,
    input  logic [31:0]       addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              ack_a,
    output logic              err_a,
    output logic [DATA_W-1:0] rdata_a,
    input  logic              req_b,
    input  logic              we_b,
    input  logic [31:0]       addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              ack_b,
    output logic              err_b,
    output logic [DATA_W-1:0] rdata_b,
    output logic [31:0]       mem_address,
    output logic              mem_write,
    output logic              mem_read,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t              state, state_nxt;
    logic                sel, sel_nxt;               // 0 = A, 1 = B
    logic                last_grant, last_grant_nxt; // 0 = A, 1 = B
    logic                ack_a_nxt, ack_b_nxt, err_a_nxt, err_b_nxt;
    logic                mem_write_nxt, mem_read_nxt;
    logic [31:0]         mem_address_nxt;
    logic [DATA_W-1:0]   mem_write_data_nxt, rdata_a_nxt, rdata_b_nxt;

    logic                grant_b, g_we, g_ok;
    logic [31:0]         g_addr;
    logic [DATA_W-1:0]   g_wdata;

    // On a tie the port that was not served last wins.
    assign grant_b = req_b && (!req_a || !last_grant);
    assign g_addr  = grant_b ? addr_b  : addr_a;
    assign g_we    = grant_b ? we_b    : we_a;
    assign g_wdata = grant_b ? wdata_b : wdata_a;
    assign g_ok    = g_addr < 32'(DEPTH);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            sel            <= 1'b0;
            last_grant     <= 1'b1;
            ack_a          <= 1'b0;
            ack_b          <= 1'b0;
            err_a          <= 1'b0;
            err_b          <= 1'b0;
            mem_write      <= 1'b0;
            mem_read       <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
            rdata_a        <= '0;
            rdata_b        <= '0;
        end else begin
            state          <= state_nxt;
            sel            <= sel_nxt;
            last_grant     <= last_grant_nxt;
            ack_a          <= ack_a_nxt;
            ack_b          <= ack_b_nxt;
            err_a          <= err_a_nxt;
            err_b          <= err_b_nxt;
            mem_write      <= mem_write_nxt;
            mem_read       <= mem_read_nxt;
            mem_address    <= mem_address_nxt;
            mem_write_data <= mem_write_data_nxt;
            rdata_a        <= rdata_a_nxt;
            rdata_b        <= rdata_b_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        sel_nxt            = sel;
        last_grant_nxt     = last_grant;
        ack_a_nxt          = 1'b0;
        ack_b_nxt          = 1'b0;
        err_a_nxt          = 1'b0;
        err_b_nxt          = 1'b0;
        mem_write_nxt      = mem_write;
        mem_read_nxt       = mem_read;
        mem_address_nxt    = mem_address;
        mem_write_data_nxt = mem_write_data;
        rdata_a_nxt        = rdata_a;
        rdata_b_nxt        = rdata_b;
        case (state)
            IDLE: begin
                if (req_a || req_b) begin
                    sel_nxt        = grant_b;
                    last_grant_nxt = grant_b;
                    if (g_ok) begin
                        mem_address_nxt    = g_addr;
                        mem_write_data_nxt = g_wdata;
                        mem_write_nxt      = g_we;
                        mem_read_nxt       = !g_we;
                        state_nxt          = ACCESS;
                    end else begin
                        // Rejected address: the memory is never touched.
                        ack_a_nxt = !grant_b;
                        ack_b_nxt = grant_b;
                        err_a_nxt = !grant_b;
                        err_b_nxt = grant_b;
                        state_nxt = RESP;
                    end
                end
            end
            ACCESS: begin
                // readData settled at the mid-cycle negedge; write commits on this edge.
                mem_write_nxt = 1'b0;
                mem_read_nxt  = 1'b0;
                if (mem_read) begin
                    if (sel) rdata_b_nxt = mem_read_data;
                    else     rdata_a_nxt = mem_read_data;
                end
                ack_a_nxt = !sel;
                ack_b_nxt = sel;
                state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_arbitro_memoria_dados.sv
// Bench for arbitro_memoria_dados: behavioural memory plus a shadow-array reference model
// checking data, errors, control pulses and round-robin order.
module tb_arbitro_memoria_dados;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = $clog2(DEPTH);

    logic              clock, reset;
    logic              req_a, we_a, ack_a, err_a;
    logic [31:0]       addr_a;
    logic [DATA_W-1:0] wdata_a, rdata_a;
    logic              req_b, we_b, ack_b, err_b;
    logic [31:0]       addr_b;
    logic [DATA_W-1:0] wdata_b, rdata_b;
    logic [31:0]       mem_address;
    logic              mem_write, mem_read;
    logic [DATA_W-1:0] mem_write_data, mem_read_data;

    int vectors, miscompares;
    logic              load_mem;
    logic [DATA_W-1:0] init_mem [DEPTH];
    logic [DATA_W-1:0] mem      [DEPTH];
    logic [DATA_W-1:0] ref_mem  [DEPTH];
    logic [DATA_W-1:0] exp_rdata [2];

    arbitro_memoria_dados #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .err_a(err_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .err_b(err_b), .rdata_b(rdata_b),
        .mem_address(mem_address), .mem_write(mem_write), .mem_read(mem_read),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Memory: writes on posedge, readData refreshed on negedge.
    always @(posedge clock) begin
        if (load_mem) mem <= init_mem;
        else if (mem_write) mem[mem_address[AW-1:0]] <= mem_write_data;
    end
    always @(negedge clock) mem_read_data <= mem[mem_address[AW-1:0]];

    // Continuous invariants: never two acks at once, never an out-of-range address driven.
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            vectors++;
            if ((ack_a && ack_b) || ((mem_read || mem_write) && mem_address >= DEPTH)) begin
                miscompares++;
                $display("FAIL invariant: ack_a=%b ack_b=%b mem_rd=%b mem_wr=%b addr=%0d (required no dual ack, addr<%0d)",
                         ack_a, ack_b, mem_read, mem_write, mem_address, DEPTH);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
    endtask

    // Drives one request on port p and returns what was observed until its ack.
    task automatic issue(input bit p, input bit w, input logic [31:0] ad, input logic [DATA_W-1:0] wd,
                         output bit got, output bit e, output logic [DATA_W-1:0] rd,
                         output int ctrl, output bit ctrl_ok);
        if (!p) begin req_a = 1'b1; we_a = w; addr_a = ad; wdata_a = wd; end
        else    begin req_b = 1'b1; we_b = w; addr_b = ad; wdata_b = wd; end
        got = 1'b0; e = 1'b0; rd = '0; ctrl = 0; ctrl_ok = 1'b1;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (mem_read || mem_write) begin
                ctrl++;
                if (mem_address !== ad || mem_write !== w || mem_read !== !w ||
                    (w && mem_write_data !== wd)) ctrl_ok = 1'b0;
            end
            if (p ? ack_b : ack_a) begin
                got = 1'b1;
                e   = p ? err_b : err_a;
                rd  = p ? rdata_b : rdata_a;
            end
        end
        if (!p) req_a = 1'b0; else req_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; load_mem = 1'b1;
        tick(); tick();
        load_mem = 1'b0;
        vectors++;
        if ({ack_a, ack_b, err_a, err_b, mem_write, mem_read, mem_address, mem_write_data, rdata_a, rdata_b} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: ack=%b%b err=%b%b wr=%b rd=%b addr=%h wd=%h ra=%h rb=%h (required all 0)",
                     ack_a, ack_b, err_a, err_b, mem_write, mem_read, mem_address, mem_write_data, rdata_a, rdata_b);
        end
        reset = 1'b1;
        tick();
        vectors++;
        if ({ack_a, ack_b, mem_write, mem_read} !== 4'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: ack=%b%b wr=%b rd=%b (required 0)", ack_a, ack_b, mem_write, mem_read);
        end
    endtask

    task automatic test_read();
        req_a = 1'b1; we_a = 1'b0; addr_a = 32'd1;
        tick();
        vectors++;
        if (mem_read !== 1'b1 || mem_write !== 1'b0 || mem_address !== 32'd1) begin
            miscompares++;
            $display("FAIL read_ctrl: rd=%b wr=%b addr=%0d (required 1 0 1)", mem_read, mem_write, mem_address);
        end
        req_a = 1'b0;
        tick();
        vectors++;
        if (mem_read !== 1'b0 || ack_a !== 1'b1 || err_a !== 1'b0 || rdata_a !== 32'd4) begin
            miscompares++;
            $display("FAIL read_ack: rd=%b ack=%b err=%b rdata=%0d (required 0 1 0 4)", mem_read, ack_a, err_a, rdata_a);
        end
        exp_rdata[0] = 32'd4;
        tick();
        vectors++;
        if (ack_a !== 1'b0 || ack_b !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_pulse: ack_a=%b ack_b=%b (required 0 after one cycle)", ack_a, ack_b);
        end
    endtask

    task automatic test_write_read();
        bit got, e, ok; int ctrl; logic [DATA_W-1:0] rd;
        issue(1'b1, 1'b1, 32'd5, 32'hAA, got, e, rd, ctrl, ok);
        ref_mem[5] = 32'hAA;
        vectors++;
        if (!got || e || ctrl != 1 || !ok) begin
            miscompares++;
            $display("FAIL b_write: got=%b err=%b ctrl_cycles=%0d ctrl_ok=%b (required 1 0 1 1)", got, e, ctrl, ok);
        end
        issue(1'b0, 1'b0, 32'd5, '0, got, e, rd, ctrl, ok);
        exp_rdata[0] = ref_mem[5];
        vectors++;
        if (!got || e || ctrl != 1 || !ok || rd !== 32'hAA || rdata_b !== exp_rdata[1]) begin
            miscompares++;
            $display("FAIL a_read_back: got=%b err=%b ctrl=%0d ok=%b rdata=%h rdata_b=%h (required 1 0 1 1 aa %h)",
                     got, e, ctrl, ok, rd, rdata_b, exp_rdata[1]);
        end
    endtask

    task automatic test_out_of_range();
        bit got, e, ok; int ctrl; logic [DATA_W-1:0] rd;
        issue(1'b0, 1'b0, 32'd40, '0, got, e, rd, ctrl, ok);
        vectors++;
        if (!got || !e || ctrl != 0 || rd !== exp_rdata[0]) begin
            miscompares++;
            $display("FAIL out_of_range: got=%b err=%b ctrl_cycles=%0d rdata=%h (required 1 1 0 %h)",
                     got, e, ctrl, rd, exp_rdata[0]);
        end
        tick();
        vectors++;
        if (err_a !== 1'b0 || ack_a !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: ack=%b err=%b (required 0 0)", ack_a, err_a);
        end
    endtask

    task automatic test_fairness();
        int k = 0;
        bit bad = 1'b0;
        apply_reset();
        we_a = 1'b0; we_b = 1'b0; addr_a = 32'd7; addr_b = 32'd9;
        req_a = 1'b1; req_b = 1'b1;
        for (int c = 0; c < 60 && k < 6; c++) begin
            tick();
            if (ack_a || ack_b) begin
                vectors++;
                // Both ports always pending: expect strict alternation starting with A.
                if (ack_a === ack_b || ack_b !== bit'(k % 2)) begin
                    miscompares++;
                    bad = 1'b1;
                    $display("FAIL fairness_order: grant %0d ack_a=%b ack_b=%b (required port %s)",
                             k, ack_a, ack_b, (k % 2) ? "B" : "A");
                end
                if (ack_a) begin exp_rdata[0] = ref_mem[7]; req_a = 1'b0; end
                if (ack_b) begin exp_rdata[1] = ref_mem[9]; req_b = 1'b0; end
                k++;
            end else begin
                req_a = 1'b1; req_b = 1'b1;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        vectors++;
        if (k != 6 || rdata_a !== exp_rdata[0] || rdata_b !== exp_rdata[1]) begin
            miscompares++;
            $display("FAIL fairness_count: grants=%0d ra=%h rb=%h (required 6 %h %h) bad=%b",
                     k, rdata_a, rdata_b, exp_rdata[0], exp_rdata[1], bad);
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid_access();
        int first = -1;
        bit seen_a = 1'b0, seen_b = 1'b0, early = 1'b0;
        req_a = 1'b1; we_a = 1'b1; addr_a = 32'd3; wdata_a = 32'h55;
        tick();
        vectors++;
        if (mem_write !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_grant: mem_write=%b (required 1)", mem_write);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if ({ack_a, ack_b, err_a, err_b, mem_write, mem_read, mem_address, mem_write_data, rdata_a, rdata_b} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: ack=%b%b wr=%b rd=%b addr=%h wd=%h ra=%h rb=%h (required all 0)",
                     ack_a, ack_b, mem_write, mem_read, mem_address, mem_write_data, rdata_a, rdata_b);
        end
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        req_b = 1'b1; we_b = 1'b0; addr_b = 32'd4;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (ack_a || ack_b) early = 1'b1;
        end
        #2 reset = 1'b1;
        for (int i = 0; i < 20 && !(seen_a && seen_b); i++) begin
            tick();
            if (ack_a && !seen_a) begin
                seen_a = 1'b1; req_a = 1'b0; ref_mem[3] = 32'h55;
                if (first < 0) first = 0;
            end
            if (ack_b && !seen_b) begin
                seen_b = 1'b1; req_b = 1'b0; exp_rdata[1] = ref_mem[4];
                if (first < 0) first = 1;
            end
        end
        req_a = 1'b0; req_b = 1'b0;
        vectors++;
        if (early || !seen_a || !seen_b || first != 0 || rdata_b !== exp_rdata[1]) begin
            miscompares++;
            $display("FAIL reset_then_order: ack_in_reset=%b seen_a=%b seen_b=%b first=%0d rb=%h (required 0 1 1 0 %h)",
                     early, seen_a, seen_b, first, rdata_b, exp_rdata[1]);
        end
        tick();
    endtask

    task automatic test_random();
        bit got, e, ok, p, w, exp_e; int ctrl, ai; logic [DATA_W-1:0] rd, wd, exp_rd; logic [31:0] ad;
        for (int n = 0; n < 80; n++) begin
            p  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            ad = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(DEPTH, 200)) : 32'($urandom_range(0, DEPTH - 1));
            wd = $urandom;
            ai = int'(ad);
            exp_e = (ai >= DEPTH);
            issue(p, w, ad, wd, got, e, rd, ctrl, ok);
            if (!exp_e && !w) exp_rdata[p] = ref_mem[ai];
            if (!exp_e && w)  ref_mem[ai] = wd;
            exp_rd = exp_rdata[p];
            vectors++;
            if (!got || e !== exp_e || ctrl != (exp_e ? 0 : 1) || !ok || rd !== exp_rd ||
                (p ? rdata_a : rdata_b) !== exp_rdata[!p]) begin
                miscompares++;
                $display("FAIL random[%0d]: port=%0d we=%b addr=%0d got=%b err=%b ctrl=%0d ok=%b rdata=%h other=%h (required err=%b ctrl=%0d rdata=%h other=%h)",
                         n, p, w, ad, got, e, ctrl, ok, rd, p ? rdata_a : rdata_b,
                         exp_e, exp_e ? 0 : 1, exp_rd, exp_rdata[!p]);
            end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        req_a = 1'b0; we_a = 1'b0; addr_a = '0; wdata_a = '0;
        req_b = 1'b0; we_b = 1'b0; addr_b = '0; wdata_b = '0;
        reset = 1'b0; load_mem = 1'b1;
        for (int i = 0; i < DEPTH; i++) init_mem[i] = $urandom;
        init_mem[1] = 32'd4;
        ref_mem = init_mem;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        test_reset();
        test_read();
        test_write_read();
        test_out_of_range();
        test_fairness();
        test_reset_mid_access();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
